// File: rtl/fifo_rd_serializer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_ser_pkg
// Shared constants and types for the FIFO read-side serializer.
//   IN_W   : FIFO word width (must match the FIFO data width)
//   OUT_W  : output beat width
//   BEATS  : beats per word, derived as IN_W / OUT_W
//   CNT_W  : width of the transmitted-word counter
//   state_t: serializer FSM states
// WIDTHS_OK is evaluated at elaboration by the top level, which refuses to
// build when a word does not split into a whole number of beats.
// ---------------------------------------------------------------------------
package fifo_rd_ser_pkg;

    localparam int IN_W   = 560;
    localparam int OUT_W  = 80;
    localparam int BEATS  = IN_W / OUT_W;
    localparam int CNT_W  = 16;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam bit WIDTHS_OK = (IN_W % OUT_W) == 0;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_serializer_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_serializer_if
// Groups the FIFO read port, the outgoing beat stream and the control/status
// signals of the serializer.
//   master modport : serializer side (drives r_en and the beat stream)
//   slave modport  : environment side (FIFO + downstream consumer)
// Signals:
//   i_en        pop permission
//   r_empty     FIFO empty flag
//   r_en        FIFO pop strobe
//   r_data      FIFO read data, valid the cycle after r_en
//   o_valid / o_ready / o_data / o_last   beat stream
//   o_word_cnt  count of fully transmitted words
//   o_par       even parity of o_data (only with FIFO_RD_SER_PARITY_EN)
// ---------------------------------------------------------------------------
interface fifo_rd_serializer_if;
    import fifo_rd_ser_pkg::*;

    logic             i_en;
    logic             r_empty;
    logic             r_en;
    logic [IN_W-1:0]  r_data;
    logic             o_valid;
    logic             o_ready;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic [CNT_W-1:0] o_word_cnt;
`ifdef FIFO_RD_SER_PARITY_EN
    logic             o_par;
`endif

    modport master (
        input  i_en,
        input  r_empty,
        input  r_data,
        input  o_ready,
        output r_en,
        output o_valid,
        output o_data,
        output o_last,
        output o_word_cnt
`ifdef FIFO_RD_SER_PARITY_EN
        , output o_par
`endif
    );

    modport slave (
        output i_en,
        output r_empty,
        output r_data,
        output o_ready,
        input  r_en,
        input  o_valid,
        input  o_data,
        input  o_last,
        input  o_word_cnt
`ifdef FIFO_RD_SER_PARITY_EN
        , input o_par
`endif
    );

endinterface

// File: rtl/fifo_rd_serializer_shreg.sv
// ---------------------------------------------------------------------------
// ser_shreg
// IN_W-bit load/shift register. A load captures a full FIFO word; a shift
// moves the word down by one beat (OUT_W bits) with zero fill at the top.
// The lowest OUT_W bits are always the current beat.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (clears to zero)
//   load       capture load_data (takes priority over shift)
//   shift      drop the lowest beat
//   load_data  full word to capture
//   low_slice  current beat, shreg[OUT_W-1:0]
// ---------------------------------------------------------------------------
module ser_shreg
    import fifo_rd_ser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [IN_W-1:0]  load_data,
    output logic [OUT_W-1:0] low_slice
);

    logic [IN_W-1:0] shreg_q;
    logic [IN_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {{OUT_W{1'b0}}, shreg_q[IN_W-1:OUT_W]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign low_slice = shreg_q[OUT_W-1:0];

endmodule

// File: rtl/fifo_rd_serializer.sv
// ---------------------------------------------------------------------------
// fifo_rd_serializer
// Read-side consumer of the wide dual-clock FIFO. Pops one IN_W word, waits
// out the one-cycle RAM read latency, then emits the word as BEATS beats of
// OUT_W bits (least significant beat first) on a valid/ready stream.
// Ports:
//   r_clk  read-domain clock, rising edge
//   rst    asynchronous active-high reset
//   bus    fifo_rd_serializer_if.master (FIFO read port, beat stream,
//          i_en, o_word_cnt and, with FIFO_RD_SER_PARITY_EN, o_par)
// Optional feature: define FIFO_RD_SER_PARITY_EN to add o_par, the even
// parity of o_data, forced low whenever no beat is valid.
// ---------------------------------------------------------------------------
module fifo_rd_serializer
    import fifo_rd_ser_pkg::*;
(
    input  logic                 r_clk,
    input  logic                 rst,
    fifo_rd_serializer_if.master bus
);

    if (!WIDTHS_OK) begin : g_width_check
        $error("fifo_rd_serializer: IN_W must be an integer multiple of OUT_W");
    end

    state_t             state_q;
    state_t             state_d;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [BEAT_W-1:0]  beat_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]   word_cnt_d;

    logic               pop;
    logic               load;
    logic               shift;
    logic               valid;
    logic [OUT_W-1:0]   beat_data;

    ser_shreg u_shreg (
        .clk       (r_clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (bus.r_data),
        .low_slice (beat_data)
    );

    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        valid      = 1'b0;
        case (state_q)
            IDLE: begin
                // The pop is combinational, so it is also masked by rst:
                // while reset is held the FIFO must not see a read strobe.
                pop = bus.i_en & ~bus.r_empty & ~rst;
                if (pop) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // r_data for the pop issued last cycle is valid now.
                load       = 1'b1;
                beat_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                valid = 1'b1;
                if (bus.o_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        state_d    = IDLE;
                    end else begin
                        shift      = 1'b1;
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.r_en       = pop;
    assign bus.o_valid    = valid;
    assign bus.o_data     = beat_data;
    assign bus.o_last     = valid & (beat_cnt_q == LAST_BEAT);
    assign bus.o_word_cnt = word_cnt_q;

`ifdef FIFO_RD_SER_PARITY_EN
    // Derived from the registered beat, so it changes in step with o_data.
    assign bus.o_par = valid & (^beat_data);
`endif

endmodule
